// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage: validates loads/stores, drives a
// single-request bus handshake with timeout, and sign/zero-extends load data.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        EX_MEM_memread,
   input  logic        EX_MEM_memwrite,
   input  logic [2:0]  EX_MEM_funct3,
   input  logic [31:0] EX_MEM_ALU_result,
   input  logic [31:0] EX_MEM_rs2_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] data_mem_read_data,
   output logic        mem_stall,
   output logic        mem_fault
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_r;
   logic [7:0]  count_r;
   logic [2:0]  funct3_r;
   logic [1:0]  lane_r;
   logic        fault_r;
   logic        access_s;
   logic        legal_s;
   logic        aligned_s;
   logic        valid_s;
   logic        invalid_s;

   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
      logic [3:0] strb;
      case (f3[1:0])
         2'b00:   strb = 4'b0001 << lane;
         2'b01:   strb = 4'b0011 << {lane[1], 1'b0};
         2'b10:   strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] data);
      logic [31:0] shifted;
      case (f3[1:0])
         2'b00:   shifted = data << {lane, 3'b000};
         2'b01:   shifted = data << {lane[1], 4'b0000};
         default: shifted = data;
      endcase
      return shifted;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [31:0] byte_w;
      logic [31:0] half_w;
      logic [31:0] result;
      byte_w = word >> {lane, 3'b000};
      half_w = word >> {lane[1], 4'b0000};
      case (f3)
         3'b000:  result = {{24{byte_w[7]}}, byte_w[7:0]};
         3'b100:  result = {24'd0, byte_w[7:0]};
         3'b001:  result = {{16{half_w[15]}}, half_w[15:0]};
         3'b101:  result = {16'd0, half_w[15:0]};
         3'b010:  result = word;
         default: result = 32'd0;
      endcase
      return result;
   endfunction

   // Decode the MEM-stage request: direction, funct3 legality and alignment.
   always_comb begin
      access_s = EX_MEM_memread | EX_MEM_memwrite;
      case (EX_MEM_funct3)
         3'b000, 3'b001, 3'b010: legal_s = 1'b1;
         3'b100, 3'b101:         legal_s = EX_MEM_memread & ~EX_MEM_memwrite;
         default:                legal_s = 1'b0;
      endcase
      case (EX_MEM_funct3[1:0])
         2'b01:   aligned_s = ~EX_MEM_ALU_result[0];
         2'b10:   aligned_s = (EX_MEM_ALU_result[1:0] == 2'b00);
         default: aligned_s = 1'b1;
      endcase
      valid_s   = (EX_MEM_memread ^ EX_MEM_memwrite) & legal_s & aligned_s;
      invalid_s = access_s & ~valid_s;
   end

   // Stall and fault must react in the IDLE cycle itself so the pipeline freezes
   // (or flags the bad access) while the instruction is still in MEM.
   assign mem_stall = ~reset & (((state_r == IDLE) & valid_s) | (state_r == REQ));
   assign mem_fault = ~reset & (((state_r == IDLE) & invalid_s) | fault_r);

   // Access sequencer: latches the request, runs the bus handshake and timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r            <= IDLE;
         count_r            <= 8'd0;
         funct3_r           <= 3'd0;
         lane_r             <= 2'd0;
         fault_r            <= 1'b0;
         dmem_req           <= 1'b0;
         dmem_we            <= 1'b0;
         dmem_addr          <= 32'd0;
         dmem_wdata         <= 32'd0;
         dmem_wstrb         <= 4'd0;
         data_mem_read_data <= 32'd0;
      end else begin
         fault_r <= 1'b0;
         case (state_r)
            IDLE: begin
               count_r <= 8'd0;
               if (valid_s) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= EX_MEM_memwrite;
                  dmem_addr  <= {EX_MEM_ALU_result[31:2], 2'b00};
                  dmem_wdata <= EX_MEM_memwrite ?
                                store_data(EX_MEM_funct3, EX_MEM_ALU_result[1:0], EX_MEM_rs2_data) :
                                32'd0;
                  dmem_wstrb <= EX_MEM_memwrite ?
                                store_strb(EX_MEM_funct3, EX_MEM_ALU_result[1:0]) : 4'd0;
                  funct3_r   <= EX_MEM_funct3;
                  lane_r     <= EX_MEM_ALU_result[1:0];
                  state_r    <= REQ;
               end else if (invalid_s) begin
                  data_mem_read_data <= 32'd0;
               end
            end
            REQ: begin
               if (dmem_ack || (count_r == TIMEOUT_LAST)) begin
                  dmem_req   <= 1'b0;
                  dmem_we    <= 1'b0;
                  dmem_addr  <= 32'd0;
                  dmem_wdata <= 32'd0;
                  dmem_wstrb <= 4'd0;
                  state_r    <= DONE;
                  // An ack arriving on the final counted cycle still wins over the timeout.
                  if (dmem_ack) begin
                     if (!dmem_we) begin
                        data_mem_read_data <= load_extend(funct3_r, lane_r, dmem_rdata);
                     end
                  end else begin
                     fault_r            <= 1'b1;
                     data_mem_read_data <= 32'd0;
                  end
               end else begin
                  count_r <= count_r + 8'd1;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a behavioural
// model of the access rules (validity, lane encoding, extension, timeout).
module tb_mem_access_unit;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread;
   logic        memwrite;
   logic [2:0]  funct3;
   logic [31:0] alu;
   logic [31:0] rs2;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] read_data;
   logic        mem_stall;
   logic        mem_fault;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_rd;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk),
      .reset(reset),
      .EX_MEM_memread(memread),
      .EX_MEM_memwrite(memwrite),
      .EX_MEM_funct3(funct3),
      .EX_MEM_ALU_result(alu),
      .EX_MEM_rs2_data(rs2),
      .dmem_req(dmem_req),
      .dmem_we(dmem_we),
      .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb),
      .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata),
      .data_mem_read_data(read_data),
      .mem_stall(mem_stall),
      .mem_fault(mem_fault)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_valid(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a);
      int nb;
      if (rd == wr) return 1'b0;
      if (f3 == 3'd3 || f3 > 3'd5) return 1'b0;
      if (wr && f3 > 3'd2) return 1'b0;
      nb = 1 << f3[1:0];
      return (int'(a[1:0]) % nb) == 0;
   endfunction

   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] w);
      int nb;
      longint unsigned mask;
      logic [31:0] v;
      nb   = 1 << f3[1:0];
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = (w >> (8 * int'(lane))) & mask[31:0];
      if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask[31:0];
      return v;
   endfunction

   // One MEM-stage instruction; entered and left just after a falling edge.
   task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdat, input int ack_at);
      bit v;
      bit timed;
      int nb;
      int stall_cnt;
      v = is_valid(rd, wr, f3, a);
      memread = rd; memwrite = wr; funct3 = f3; alu = a; rs2 = d;
      dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #1;
      check_eq("idle_stall", 32'(mem_stall), 32'(v));
      check_eq("idle_fault", 32'(mem_fault), 32'((rd | wr) & !v));
      check_eq("idle_req", 32'(dmem_req), 32'd0);
      if (!(rd | wr)) begin
         check_eq("idle_hold", read_data, exp_rd);
         @(negedge clk);
      end else if (!v) begin
         exp_rd = 32'd0;
         @(negedge clk);
         memread = 1'b0; memwrite = 1'b0;
         #1;
         check_eq("bad_rdata", read_data, exp_rd);
         check_eq("bad_req", 32'(dmem_req), 32'd0);
         check_eq("bad_fault_pulse", 32'(mem_fault), 32'd0);
         @(negedge clk);
      end else begin
         nb = 1 << f3[1:0];
         stall_cnt = (mem_stall === 1'b1) ? 1 : 0;
         @(negedge clk);
         for (int c = 0; c < T; c++) begin
            dmem_ack = (c == ack_at);
            dmem_rdata = (c == ack_at) ? rdat : $urandom;
            #1;
            if (mem_stall === 1'b1) stall_cnt++;
            check_eq("req_req", 32'(dmem_req), 32'd1);
            check_eq("req_fault", 32'(mem_fault), 32'd0);
            check_eq("req_we", 32'(dmem_we), 32'(wr));
            check_eq("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
            check_eq("req_wstrb", 32'(dmem_wstrb),
                     wr ? 32'(((1 << nb) - 1) << int'(a[1:0])) : 32'd0);
            if (wr) check_eq("req_wdata", dmem_wdata, d << (8 * int'(a[1:0])));
            @(negedge clk);
            if (c == ack_at) break;
         end
         timed = (ack_at >= T);
         if (timed) exp_rd = 32'd0;
         else if (rd) exp_rd = load_model(f3, a[1:0], rdat);
         dmem_ack = 1'($urandom_range(0, 1));
         #1;
         if (mem_stall === 1'b1) stall_cnt++;
         check_eq("done_req", 32'(dmem_req), 32'd0);
         check_eq("done_fault", 32'(mem_fault), 32'(timed));
         check_eq("done_rdata", read_data, exp_rd);
         check_eq("stall_cycles", 32'(stall_cnt), timed ? 32'(T + 1) : 32'(ack_at + 2));
         @(negedge clk);
      end
      dmem_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0; alu = 32'd0; rs2 = 32'd0;
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
      exp_rd = 32'd0;
      #2;
      check_eq("rst_req", 32'(dmem_req), 32'd0);
      check_eq("rst_addr", dmem_addr, 32'd0);
      check_eq("rst_rdata", read_data, 32'd0);
      check_eq("rst_stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // LB with sign extension from lane 3, ack on the first REQ cycle
      access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h8011_2233, 0);
      check_eq("lb_value", read_data, 32'hFFFF_FF80);
      access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 1);
      access(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 0);
      access(1'b1, 1'b0, 3'b101, 32'h0000_4000, 32'd0, 32'd0, T);
      access(1'b1, 1'b1, 3'b010, 32'h0000_5000, 32'd0, 32'd0, 0);
      access(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'hCAFE_F00D, 0);
      access(1'b0, 1'b1, 3'b010, 32'h0000_6004, 32'h1234_5678, 32'd0, 0);
      access(1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'd0, 32'd0, 0);

      // Reset in the second REQ cycle of a slow LW; the late ack must be ignored
      memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; alu = 32'h0000_7000; rs2 = 32'd0;
      dmem_ack = 1'b0;
      #1;
      check_eq("rr_idle_stall", 32'(mem_stall), 32'd1);
      @(negedge clk);
      #1;
      check_eq("rr_req", 32'(dmem_req), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("rr_req0", 32'(dmem_req), 32'd0);
      check_eq("rr_we0", 32'(dmem_we), 32'd0);
      check_eq("rr_addr0", dmem_addr, 32'd0);
      check_eq("rr_wdata0", dmem_wdata, 32'd0);
      check_eq("rr_wstrb0", 32'(dmem_wstrb), 32'd0);
      check_eq("rr_rdata0", read_data, 32'd0);
      check_eq("rr_stall0", 32'(mem_stall), 32'd0);
      check_eq("rr_fault0", 32'(mem_fault), 32'd0);
      memread = 1'b0;
      exp_rd = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      #1;
      check_eq("late_ack_req", 32'(dmem_req), 32'd0);
      check_eq("late_ack_fault", 32'(mem_fault), 32'd0);
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      check_eq("late_ack_rdata", read_data, 32'd0);
      check_eq("late_ack_stall", 32'(mem_stall), 32'd0);
      @(negedge clk);

      for (int i = 0; i < 300; i++) begin
         int  kind;
         bit  rd;
         bit  wr;
         kind = int'($urandom_range(0, 9));
         rd = (kind == 1) || (kind >= 2 && kind[0]);
         wr = (kind == 1) || (kind >= 2 && !kind[0]);
         access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, T + 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
